dram_ctrl: RTL and testbench

//  Sequences the off-chip DRAM: accepts single-word read/write requests on a valid/ready port
//  and issues PRE/ACT/RD/WR commands on the DRAM_* pins with the programmed timing.

---
 rtl/dram_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dram_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
`default_nettype none
// dram_ctrl: single-word DRAM command sequencer (PRE/ACT/RD/WR), open-page policy.
// Revision 1.0 - initial release.
module dram_ctrl #(
   parameter int T_RP  = 3,
   parameter int T_RCD = 3,
   parameter int T_WR  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [21:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        DRAM_CSn,
   output logic        DRAM_RASn,
   output logic        DRAM_CASn,
   output logic [3:0]  DRAM_WEn,
   output logic [10:0] DRAM_A,
   output logic [31:0] DRAM_D,
   input  logic [31:0] DRAM_Q,
   input  logic        DRAM_valid
);

   typedef enum logic [3:0] {
      IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RD, RD_WAIT, WR, WR_WAIT, RESP
   } state_t;

   localparam int CW = 8;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          row_open;
   logic [10:0]   open_row;
   logic [10:0]   row_q;
   logic [10:0]   col_q;
   logic          write_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;

   logic          accept;
   logic          hit;
   logic          go_pre;
   logic          go_act;
   logic          go_col;
   logic [10:0]   row_sel;
   logic [10:0]   col_sel;
   logic          wr_sel;
   logic [31:0]   wdata_sel;
   logic [3:0]    wstrb_sel;

   // Commands issued straight from IDLE use the live request; later ones use the latched copy.
   always_comb begin
      accept    = (state == IDLE) && req_valid && req_ready;
      hit       = row_open && (req_addr[21:11] == open_row);
      row_sel   = (state == IDLE) ? req_addr[21:11] : row_q;
      col_sel   = (state == IDLE) ? req_addr[10:0]  : col_q;
      wr_sel    = (state == IDLE) ? req_write       : write_q;
      wdata_sel = (state == IDLE) ? req_wdata       : wdata_q;
      wstrb_sel = (state == IDLE) ? req_wstrb       : wstrb_q;
      go_pre    = accept && row_open && !hit;
      go_act    = (accept && !row_open)
                  || ((state == PRE) && (T_RP == 1))
                  || ((state == PRE_WAIT) && (cnt == '0));
      go_col    = (accept && hit)
                  || ((state == ACT) && (T_RCD == 1))
                  || ((state == ACT_WAIT) && (cnt == '0));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         row_open  <= 1'b0;
         open_row  <= '0;
         row_q     <= '0;
         col_q     <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hF;
         DRAM_A    <= '0;
         DRAM_D    <= '0;
      end else begin
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hF;
         rsp_valid <= 1'b0;
         req_ready <= 1'b0;

         if (accept) begin
            row_q   <= req_addr[21:11];
            col_q   <= req_addr[10:0];
            write_q <= req_write;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
         end

         if (go_pre) begin
            state     <= PRE;
            row_open  <= 1'b0;
            DRAM_CSn  <= 1'b0;
            DRAM_RASn <= 1'b0;
            DRAM_WEn  <= 4'h0;
            DRAM_A    <= '0;
         end else if (go_act) begin
            state     <= ACT;
            row_open  <= 1'b1;
            open_row  <= row_sel;
            DRAM_CSn  <= 1'b0;
            DRAM_RASn <= 1'b0;
            DRAM_A    <= row_sel;
         end else if (go_col) begin
            state     <= wr_sel ? WR : RD;
            DRAM_CSn  <= 1'b0;
            DRAM_CASn <= 1'b0;
            DRAM_A    <= col_sel;
            if (wr_sel) begin
               DRAM_WEn <= ~wstrb_sel;
               DRAM_D   <= wdata_sel;
            end
         end else begin
            // Wait states reaching zero are handled by go_act/go_col above.
            case (state)
               IDLE:     req_ready <= 1'b1;
               PRE: begin
                  state <= PRE_WAIT;
                  cnt   <= CW'(T_RP - 2);
               end
               PRE_WAIT: cnt <= cnt - 1'b1;
               ACT: begin
                  state <= ACT_WAIT;
                  cnt   <= CW'(T_RCD - 2);
               end
               ACT_WAIT: cnt <= cnt - 1'b1;
               RD:       state <= RD_WAIT;
               RD_WAIT: begin
                  if (DRAM_valid) begin
                     rsp_rdata <= DRAM_Q;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
               WR: begin
                  if (T_WR == 1) begin
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     state <= WR_WAIT;
                     cnt   <= CW'(T_WR - 2);
                  end
               end
               WR_WAIT: begin
                  if (cnt == '0) begin
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               RESP: begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
               default:  state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// tb_dram_ctrl: scoreboard bench for dram_ctrl with a behavioural DRAM responder.
// Revision 1.0 - initial release.
module tb_dram_ctrl;

   localparam int T_RP  = 3;
   localparam int T_RCD = 3;
   localparam int T_WR  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [21:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic [31:0] DRAM_Q;
   logic        DRAM_valid;

   always #5 clk = ~clk;

   dram_ctrl #(.T_RP(T_RP), .T_RCD(T_RCD), .T_WR(T_WR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
      .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
      .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] sb[$];
   logic [31:0] dram_mem[logic [21:0]];
   logic [31:0] shadow[logic [21:0]];
   logic [31:0] last_rd = '0;

   int          n_pre = 0, n_act = 0, n_col = 0, rsp_cnt = 0;
   int          t_pre = 0, t_act = 0, t_col = 0, t_rsp = 0, t_acc = 0;
   logic [10:0] a_act = '0, a_col = '0, act_row = '0;
   logic [3:0]  wen_col = '0;
   logic [31:0] d_col = '0;
   int          lat = 2;
   int          pend = 0;
   logic [31:0] rd_q = '0;
   logic        cur_write = 1'b0;
   logic        spurious = 1'b0;

   // DRAM responder and pin/response monitor share one process to keep negedge ordering fixed.
   initial begin : dram_model
      logic [31:0] v;
      DRAM_valid = 1'b0;
      DRAM_Q     = '0;
      forever begin
         @(negedge clk);
         DRAM_valid = 1'b0;
         if (!rst) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  DRAM_valid = 1'b1;
                  DRAM_Q     = rd_q;
               end
            end
            if (spurious) begin
               DRAM_valid = 1'b1;
               DRAM_Q     = 32'hBAD0BAD0;
               spurious   = 1'b0;
            end
            if (rsp_valid) begin
               rsp_cnt++;
               t_rsp = cyc;
               check("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) check("rsp_rdata", rsp_rdata, sb.pop_front());
            end
            if (!DRAM_CSn) begin
               if (!DRAM_RASn && DRAM_CASn) begin
                  if (DRAM_WEn == 4'h0) begin
                     n_pre++;
                     t_pre = cyc;
                     check("pre_addr", DRAM_A, 0);
                  end else begin
                     n_act++;
                     t_act   = cyc;
                     a_act   = DRAM_A;
                     act_row = DRAM_A;
                  end
               end else if (DRAM_RASn && !DRAM_CASn) begin
                  n_col++;
                  t_col   = cyc;
                  a_col   = DRAM_A;
                  wen_col = DRAM_WEn;
                  d_col   = DRAM_D;
                  v = dram_mem.exists({act_row, DRAM_A}) ? dram_mem[{act_row, DRAM_A}] : 32'h0;
                  if (cur_write) begin
                     for (int b = 0; b < 4; b++)
                        if (!DRAM_WEn[b]) v[8*b +: 8] = DRAM_D[8*b +: 8];
                     dram_mem[{act_row, DRAM_A}] = v;
                  end else begin
                     rd_q = v;
                     pend = lat;
                  end
               end
            end
         end
      end
   end

   task automatic do_req(input logic w, input logic [21:0] addr, input logic [31:0] wd,
                         input logic [3:0] st);
      logic [31:0] v;
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      check("req_ready_wait", req_ready, 1);
      n_pre = 0; n_act = 0; n_col = 0;
      cur_write = w;
      t_acc = cyc;
      v = shadow.exists(addr) ? shadow[addr] : 32'h0;
      if (w) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
         shadow[addr] = v;
         sb.push_back(last_rd);
      end else begin
         sb.push_back(v);
         last_rd = v;
      end
      req_valid = 1'b1;
      req_write = w;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = st;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n0 = rsp_cnt;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (rsp_cnt != n0) break;
      end
      check("rsp_seen", rsp_cnt != n0, 1);
   endtask

   initial begin : stim
      int n0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

      // Reset state
      repeat (5) @(negedge clk);
      check("rst_csn", DRAM_CSn, 1);
      check("rst_rasn", DRAM_RASn, 1);
      check("rst_casn", DRAM_CASn, 1);
      check("rst_wen", DRAM_WEn, 4'hF);
      check("rst_a", DRAM_A, 0);
      check("rst_d", DRAM_D, 0);
      check("rst_ready", req_ready, 0);
      check("rst_rspv", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      rst = 1'b1;
      #1 check("ready_at_release", req_ready, 0);
      @(negedge clk);
      check("ready_after_release", req_ready, 1);

      // Cold write: ACT then WR, no PRE
      do_req(1'b1, 22'h000805, 32'hDEADBEEF, 4'hF);
      wait_rsp();
      check("w1_npre", n_pre, 0);
      check("w1_nact", n_act, 1);
      check("w1_act_a", a_act, 1);
      check("w1_act_t", t_act - t_acc, 1);
      check("w1_rcd", t_col - t_act, T_RCD);
      check("w1_col_a", a_col, 5);
      check("w1_wen", wen_col, 4'h0);
      check("w1_d", d_col, 32'hDEADBEEF);
      check("w1_twr", t_rsp - t_col, T_WR);

      // Read hit
      do_req(1'b0, 22'h000805, 32'h0, 4'h0);
      wait_rsp();
      check("r1_npre", n_pre, 0);
      check("r1_nact", n_act, 0);
      check("r1_rd_t", t_col - t_acc, 1);
      check("r1_col_a", a_col, 5);
      check("r1_lat", t_rsp - t_acc, 2 + lat);

      // Read miss to row 2
      do_req(1'b0, 22'h001003, 32'h0, 4'h0);
      wait_rsp();
      check("r2_npre", n_pre, 1);
      check("r2_pre_t", t_pre - t_acc, 1);
      check("r2_trp", t_act - t_pre, T_RP);
      check("r2_act_a", a_act, 2);
      check("r2_rcd", t_col - t_act, T_RCD);
      check("r2_col_a", a_col, 3);

      // Partial write, then spurious DRAM_valid while idle
      do_req(1'b1, 22'h001003, 32'h11223344, 4'b0101);
      wait_rsp();
      check("w2_wen", wen_col, 4'b1010);
      check("w2_d", d_col, 32'h11223344);
      check("w2_nact", n_act, 0);
      n0 = rsp_cnt;
      spurious = 1'b1;
      repeat (4) @(negedge clk);
      #1 check("spurious_no_rsp", rsp_cnt, n0);
      do_req(1'b0, 22'h001003, 32'h0, 4'h0);
      wait_rsp();

      // Write with no byte enables still completes, writes nothing
      do_req(1'b1, 22'h001004, 32'hFFFFFFFF, 4'h0);
      wait_rsp();
      check("w3_wen", wen_col, 4'hF);
      check("w3_ncol", n_col, 1);
      do_req(1'b0, 22'h001004, 32'h0, 4'h0);
      wait_rsp();

      // Reset during RD_WAIT
      lat = 20;
      do_req(1'b0, 22'h001003, 32'h0, 4'h0);
      for (int i = 0; i < 10 && n_col == 0; i++) @(negedge clk);
      check("r4_rd_issued", n_col, 1);
      repeat (3) @(negedge clk);
      n0 = rsp_cnt;
      rst = 1'b0;
      #1;
      check("mid_rst_csn", DRAM_CSn, 1);
      check("mid_rst_rasn", DRAM_RASn, 1);
      check("mid_rst_casn", DRAM_CASn, 1);
      check("mid_rst_wen", DRAM_WEn, 4'hF);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_rspv", rsp_valid, 0);
      repeat (3) @(negedge clk);
      sb.delete();
      last_rd = '0;
      lat = 2;
      rst = 1'b1;
      repeat (25) @(negedge clk);
      #1 check("mid_rst_no_rsp", rsp_cnt, n0);
      do_req(1'b0, 22'h001003, 32'h0, 4'h0);
      wait_rsp();
      check("r5_npre", n_pre, 0);
      check("r5_nact", n_act, 1);
      check("r5_act_a", a_act, 2);

      check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
